// File: rtl/pipeline_mode_ctrl.sv
// Pipeline-mode controller: run / flush / memory-wait / instruction-load sequencing
// with saturating stall and flush statistics. All outputs are decoded from flops.
module pipeline_mode_ctrl #(
  parameter int unsigned N_MEM         = 2,
  parameter int unsigned FLUSH_CYCLES  = 3,
  parameter int unsigned LOAD_ON_RESET = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branchJump,
  input  logic [N_MEM-1:0] requestDone,
  input  logic             regWriteCollision,
  input  logic             loadReq,
  input  logic             loadDone,
  input  logic             statClear,
  output logic             MASTER_HOLD,
  output logic             FLUSH_HOLD,
  output logic             LOAD_MODE,
  output logic [1:0]       modeState,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam int unsigned CTR_W = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CTR_W-1:0] CtrInit = CTR_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StFlush   = 2'b01,
    StMemWait = 2'b10,
    StLoad    = 2'b11
  } state_e;

  localparam state_e ResetState = (LOAD_ON_RESET != 0) ? StLoad : StRun;

  state_e           stateQ, stateD;
  logic [CTR_W-1:0] flushCtrQ, flushCtrD;
  logic             pendFlushQ, pendFlushD;
  logic [CNT_W-1:0] stallCyclesQ, flushCountQ;
  logic             memWait;
  logic             enterFlush;

  assign memWait    = (~&requestDone) | regWriteCollision;
  assign enterFlush = (stateD == StFlush) && (stateQ != StFlush);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ     <= ResetState;
      flushCtrQ  <= '0;
      pendFlushQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      flushCtrQ  <= flushCtrD;
      pendFlushQ <= pendFlushD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD     = stateQ;
    flushCtrD  = flushCtrQ;
    pendFlushD = pendFlushQ;
    unique case (stateQ)
      StRun: begin
        if (loadReq) begin
          stateD     = StLoad;
          pendFlushD = 1'b0;
        end else if (memWait) begin
          stateD = StMemWait;
          if (branchJump) pendFlushD = 1'b1;
        end else if (branchJump) begin
          stateD    = StFlush;
          flushCtrD = CtrInit;
        end
      end
      StMemWait: begin
        if (!memWait) begin
          if (pendFlushQ || branchJump) begin
            stateD     = StFlush;
            flushCtrD  = CtrInit;
            pendFlushD = 1'b0;
          end else begin
            stateD = StRun;
          end
        end else if (branchJump) begin
          pendFlushD = 1'b1;
        end
      end
      StFlush: begin
        // Branches and load requests here come from squashed instructions.
        if (flushCtrQ != '0) begin
          flushCtrD = flushCtrQ - CTR_W'(1);
        end else begin
          stateD = memWait ? StMemWait : StRun;
        end
      end
      StLoad: begin
        if (loadDone) begin
          stateD    = StFlush;
          flushCtrD = CtrInit;
        end
      end
      default: stateD = ResetState;
    endcase
  end

  // Statistics counters
  always_ff @(posedge clk) begin
    if (!rst_n || statClear) begin
      stallCyclesQ <= '0;
      flushCountQ  <= '0;
    end else begin
      if (MASTER_HOLD && (stallCyclesQ != '1)) stallCyclesQ <= stallCyclesQ + CNT_W'(1);
      if (enterFlush && (flushCountQ != '1))   flushCountQ  <= flushCountQ + CNT_W'(1);
    end
  end

  // Output decode
  always_comb begin
    MASTER_HOLD = (stateQ == StMemWait) || (stateQ == StLoad);
    FLUSH_HOLD  = (stateQ == StFlush);
    LOAD_MODE   = (stateQ == StLoad);
    modeState   = stateQ;
    stallCycles = stallCyclesQ;
    flushCount  = flushCountQ;
  end

endmodule

// File: tb/tb_pipeline_mode_ctrl.sv
// Bench for pipeline_mode_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural mode model.
module tb_pipeline_mode_ctrl;

  localparam int unsigned NMem   = 2;
  localparam int unsigned FlushN = 3;
  localparam int unsigned CntW   = 4;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  // Model modes are deliberately not the hardware encoding.
  localparam int MRun = 10, MFlush = 20, MWait = 30, MLoad = 40;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            branchJump = 1'b0;
  logic [NMem-1:0] requestDone = '1;
  logic            regWriteCollision = 1'b0;
  logic            loadReq = 1'b0;
  logic            loadDone = 1'b0;
  logic            statClear = 1'b0;
  logic            MASTER_HOLD, FLUSH_HOLD, LOAD_MODE;
  logic [1:0]      modeState;
  logic [CntW-1:0] stallCycles, flushCount;

  int nVectors = 0;
  int nMiscompares = 0;

  int mMode = MLoad, mFlushLeft = 0, mStall = 0, mFlushes = 0;
  bit mPend = 1'b0;

  pipeline_mode_ctrl #(
    .N_MEM        (NMem),
    .FLUSH_CYCLES (FlushN),
    .LOAD_ON_RESET(1),
    .CNT_W        (CntW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .branchJump       (branchJump),
    .requestDone      (requestDone),
    .regWriteCollision(regWriteCollision),
    .loadReq          (loadReq),
    .loadDone         (loadDone),
    .statClear        (statClear),
    .MASTER_HOLD      (MASTER_HOLD),
    .FLUSH_HOLD       (FLUSH_HOLD),
    .LOAD_MODE        (LOAD_MODE),
    .modeState        (modeState),
    .stallCycles      (stallCycles),
    .flushCount       (flushCount)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int mode_code(input int m);
    case (m)
      MRun:    return 0;
      MFlush:  return 1;
      MWait:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= int'(CntMax)) ? v : v + 1;
  endfunction

  task automatic enter_flush();
    mMode      = MFlush;
    mFlushLeft = FlushN;
    mFlushes   = sat_inc(mFlushes);
  endtask

  // Applies one rising edge worth of behaviour, using the inputs held at that edge.
  task automatic model_tick();
    bit memWait;
    bit holding;
    memWait = (requestDone != '1) || regWriteCollision;
    holding = (mMode == MWait) || (mMode == MLoad);
    if (!rst_n) begin
      mMode = MLoad; mFlushLeft = 0; mPend = 0; mStall = 0; mFlushes = 0;
      return;
    end
    if (statClear) begin
      mStall = 0;
    end else if (holding) begin
      mStall = sat_inc(mStall);
    end
    case (mMode)
      MRun: begin
        if (loadReq) begin
          mMode = MLoad; mPend = 0;
        end else if (memWait) begin
          mMode = MWait; if (branchJump) mPend = 1;
        end else if (branchJump) begin
          enter_flush();
        end
      end
      MWait: begin
        if (branchJump) mPend = 1;
        if (!memWait) begin
          if (mPend) begin
            mPend = 0; enter_flush();
          end else begin
            mMode = MRun;
          end
        end
      end
      MFlush: begin
        if (mFlushLeft > 1) mFlushLeft--;
        else mMode = memWait ? MWait : MRun;
      end
      default: if (loadDone) enter_flush();
    endcase
    if (statClear) mFlushes = 0;
  endtask

  task automatic step(input bit rn, input bit bj, input logic [NMem-1:0] rd, input bit rwc,
                      input bit lr, input bit ld, input bit sc);
    rst_n = rn; branchJump = bj; requestDone = rd; regWriteCollision = rwc;
    loadReq = lr; loadDone = ld; statClear = sc;
    @(posedge clk);
    model_tick();
    #1;
    check_eq("modeState", 32'(modeState), 32'(mode_code(mMode)));
    check_eq("MASTER_HOLD", 32'(MASTER_HOLD), 32'((mMode == MWait) || (mMode == MLoad)));
    check_eq("FLUSH_HOLD", 32'(FLUSH_HOLD), 32'(mMode == MFlush));
    check_eq("LOAD_MODE", 32'(LOAD_MODE), 32'(mMode == MLoad));
    check_eq("stallCycles", 32'(stallCycles), 32'(mStall));
    check_eq("flushCount", 32'(flushCount), 32'(mFlushes));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '1, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset into LOAD, loadDone at cycle 5, then a 3-cycle flush.
    step(0, 0, '1, 0, 0, 0, 0);
    step(0, 0, '1, 0, 0, 0, 0);
    idle(4);
    check_eq("load_mode_held", 32'(LOAD_MODE), 32'd1);
    step(1, 0, '1, 0, 0, 1, 0);
    idle(5);
    check_eq("flush_after_load", 32'(flushCount), 32'd1);
    // Lone branch in RUN.
    step(1, 1, '1, 0, 0, 0, 0);
    idle(5);
    // Memory stall of 4 cycles with a branch in its second cycle.
    step(1, 0, 2'b01, 0, 0, 0, 1);
    step(1, 1, 2'b01, 0, 0, 0, 0);
    step(1, 0, 2'b01, 0, 0, 0, 0);
    step(1, 0, 2'b01, 0, 0, 0, 0);
    idle(6);
    // memWait rises during flush and outlasts it by 2 cycles.
    step(1, 1, '1, 0, 0, 0, 0);
    step(1, 0, '1, 1, 0, 0, 0);
    step(1, 0, '1, 1, 0, 0, 0);
    step(1, 0, '1, 1, 0, 0, 0);
    step(1, 0, '1, 1, 0, 0, 0);
    idle(3);
    // Long collision stall saturates stallCycles, then clear.
    for (int i = 0; i < 20; i++) step(1, 0, '1, 1, 0, 0, 0);
    check_eq("stall_saturated", 32'(stallCycles), CntMax);
    step(1, 0, '1, 0, 0, 0, 1);
    check_eq("stall_cleared", 32'(stallCycles), 32'd0);
    // Reset mid-flush with a pending branch.
    step(1, 1, 2'b10, 0, 0, 0, 0);
    step(1, 1, 2'b10, 0, 0, 0, 0);
    step(1, 0, '1, 0, 0, 0, 0);
    step(1, 0, '1, 0, 0, 0, 0);
    step(0, 0, '1, 0, 0, 0, 0);
    step(1, 0, '1, 0, 0, 1, 0);
    idle(4);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [NMem-1:0] rd;
      for (int b = 0; b < int'(NMem); b++) rd[b] = ($urandom_range(3) != 0);
      step($urandom_range(299) != 0, $urandom_range(5) == 0, rd, $urandom_range(9) == 0,
           $urandom_range(29) == 0, $urandom_range(7) == 0, $urandom_range(63) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
